// File: rtl/isp_src_align_mux.sv
// Latency-aligned, frame-synchronous N-way source selector for the ISP colour path.
// Optional frame statistics (oFRAME_CNT/oSEL_CHG) enabled by `define ISP_FRAME_STAT_EN.
module isp_src_align_mux #(
  parameter int DW = 8,
  parameter int NCH = 3,
  parameter int NSRC = 3,
  parameter logic [8*NSRC-1:0] SRC_LAT = {8'd5, 8'd3, 8'd1},
  parameter int LAT_MAX = 5,
  localparam int SELW = NSRC > 1 ? $clog2(NSRC) : 1
) (
  input  logic                     VGA_CLK,
  input  logic                     RST,
  input  logic                     iVS,
  input  logic                     iDVAL,
  input  logic [SELW-1:0]          iSEL,
  input  logic [NSRC*NCH*DW-1:0]   iSRC_DATA,
  output logic [NCH*DW-1:0]        oDATA,
  output logic                     oDVAL,
  output logic                     oVS,
  output logic [SELW-1:0]          oSEL,
  output logic [15:0]              oFRAME_CNT,
  output logic                     oSEL_CHG
);

  localparam int PW = NCH * DW;

  logic [PW-1:0]   aligned [NSRC];
  logic            dVAL;
  logic            dVS;
  logic            vsPrev;
  logic [SELW-1:0] pendSel;
  logic [SELW-1:0] actSel;
  logic [SELW-1:0] selNext;
  logic [PW-1:0]   muxData;
  logic            vsRise;
  logic            dVsRise;
  logic            selOk;

  for (genvar i = 0; i < NSRC; i++) begin : gSrc
    localparam int LAT = int'(SRC_LAT[8*i +: 8]);
    localparam int DEPTH = LAT_MAX - LAT;
    if (LAT > LAT_MAX) begin : gBad
      $error("isp_src_align_mux: SRC_LAT exceeds LAT_MAX");
    end else if (DEPTH == 0) begin : gWire
      assign aligned[i] = iSRC_DATA[i*PW +: PW];
    end else begin : gDly
      logic [PW-1:0] dly [DEPTH];
      always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
          for (int j = 0; j < DEPTH; j++) dly[j] <= '0;
        end else begin
          dly[0] <= iSRC_DATA[i*PW +: PW];
          for (int j = 1; j < DEPTH; j++) dly[j] <= dly[j-1];
        end
      end
      assign aligned[i] = dly[DEPTH-1];
    end
  end

  if (LAT_MAX == 0) begin : gCtlWire
    assign dVAL = iDVAL;
    assign dVS = iVS;
  end else begin : gCtlDly
    logic [LAT_MAX-1:0] valSr;
    logic [LAT_MAX-1:0] vsSr;
    always_ff @(posedge VGA_CLK or posedge RST) begin
      if (RST) begin
        valSr <= '0;
        vsSr <= '0;
      end else begin
        valSr <= (valSr << 1) | LAT_MAX'(iDVAL);
        vsSr <= (vsSr << 1) | LAT_MAX'(iVS);
      end
    end
    assign dVAL = valSr[LAT_MAX-1];
    assign dVS = vsSr[LAT_MAX-1];
  end

  // oVS is dVS one cycle late, so it doubles as the dVS edge history
  assign vsRise = iVS & ~vsPrev;
  assign dVsRise = dVS & ~oVS;
  assign selOk = {1'b0, iSEL} < (SELW+1)'(NSRC);
  assign selNext = dVsRise ? pendSel : actSel;

  always_comb begin
    muxData = '0;
    for (int i = 0; i < NSRC; i++)
      if (selNext == SELW'(i)) muxData = aligned[i];
  end

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      vsPrev <= 1'b0;
      pendSel <= '0;
      actSel <= '0;
      oDATA <= '0;
      oDVAL <= 1'b0;
      oVS <= 1'b0;
    end else begin
      vsPrev <= iVS;
      if (vsRise && selOk) pendSel <= iSEL;
      actSel <= selNext;
      oDVAL <= dVAL;
      oVS <= dVS;
      oDATA <= dVAL ? muxData : '0;
    end
  end

  assign oSEL = actSel;

`ifdef ISP_FRAME_STAT_EN
  logic [15:0] frameCnt;
  logic        selChg;

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      frameCnt <= '0;
      selChg <= 1'b0;
    end else begin
      if (dVsRise) frameCnt <= frameCnt + 16'd1;
      selChg <= selNext != actSel;
    end
  end

  assign oFRAME_CNT = frameCnt;
  assign oSEL_CHG = selChg;
`else
  assign oFRAME_CNT = 16'd0;
  assign oSEL_CHG = 1'b0;
`endif

endmodule
